// File: rtl/vec_pair_feeder_pkg.sv
// Shared definitions for the sum-of-squares operand path (feeder, ALU, accumulator):
// default widths, the FP zero word and the feeder FSM state encoding.
package vec_pair_feeder_pkg;

  localparam int DATA_W = 24;
  localparam int ADDR_W = 8;
  localparam int LEN_W  = 9;

  localparam logic [23:0] FP_ZERO = 24'h000000;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_RD_X    = 3'd1;
  localparam logic [2:0] ST_RD_Y    = 3'd2;
  localparam logic [2:0] ST_CAP_Y   = 3'd3;
  localparam logic [2:0] ST_PRESENT = 3'd4;
  localparam logic [2:0] ST_FIN     = 3'd5;

  typedef enum logic [2:0] {
    IDLE    = ST_IDLE,
    RD_X    = ST_RD_X,
    RD_Y    = ST_RD_Y,
    CAP_Y   = ST_CAP_Y,
    PRESENT = ST_PRESENT,
    FIN     = ST_FIN
  } state_t;

endpackage

// File: rtl/vec_feeder_stats.sv
// Per-vector transfer and stall counters for vec_pair_feeder (VEC_PAIR_FEEDER_STATS_EN builds only).
module vec_feeder_stats #(
  parameter int LEN_W = vec_pair_feeder_pkg::LEN_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             xfer,
  input  logic             stall,
  output logic [LEN_W-1:0] stat_pairs,
  output logic [15:0]      stat_stalls
);

  // Counters restart on every accepted start; the stall count saturates.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_pairs  <= '0;
      stat_stalls <= 16'h0000;
    end else if (clr) begin
      stat_pairs  <= '0;
      stat_stalls <= 16'h0000;
    end else begin
      if (xfer) begin
        stat_pairs <= stat_pairs + LEN_W'(1);
      end
      if (stall && (stat_stalls != 16'hFFFF)) begin
        stat_stalls <= stat_stalls + 16'd1;
      end
    end
  end

endmodule

// File: rtl/vec_pair_feeder.sv
// Reads a vector from sync-read element memory and presents it as (x, y) pairs with valid/ready.
// Optional stat_pairs/stat_stalls outputs are built when VEC_PAIR_FEEDER_STATS_EN is defined.
module vec_pair_feeder #(
  parameter int DATA_W = vec_pair_feeder_pkg::DATA_W,
  parameter int ADDR_W = vec_pair_feeder_pkg::ADDR_W,
  parameter int LEN_W  = vec_pair_feeder_pkg::LEN_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [LEN_W-1:0]  length,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] x,
  output logic [DATA_W-1:0] y,
  output logic              pair_valid,
  input  logic              pair_ready,
  output logic              pair_last,
  output logic              busy,
  output logic              done
`ifdef VEC_PAIR_FEEDER_STATS_EN
  ,
  output logic [LEN_W-1:0]  stat_pairs,
  output logic [15:0]       stat_stalls
`endif
);

  import vec_pair_feeder_pkg::*;

  state_t            state_r, state_s;
  logic [ADDR_W-1:0] base_r, base_s;
  logic [ADDR_W-1:0] idx_r, idx_s;
  logic [LEN_W-1:0]  rem_r, rem_s;
  logic [DATA_W-1:0] x_r, x_s, y_r, y_s;
  logic              valid_r, valid_s, last_r, last_s;
  logic              rd_en_r, rd_en_s;
  logic [ADDR_W-1:0] addr_r, addr_s;
  logic              busy_r, done_r;

  // Next-state and next-output logic; read strobes are decided one state early so they leave a flop.
  always_comb begin
    state_s = state_r;
    base_s  = base_r;
    idx_s   = idx_r;
    rem_s   = rem_r;
    x_s     = x_r;
    y_s     = y_r;
    valid_s = valid_r;
    last_s  = last_r;
    rd_en_s = 1'b0;
    addr_s  = addr_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          base_s = base_addr;
          idx_s  = '0;
          rem_s  = length;
          if (length != '0) begin
            state_s = RD_X;
            rd_en_s = 1'b1;
            addr_s  = base_addr;
          end else begin
            state_s = FIN;
          end
        end else begin
          state_s = IDLE;
        end
      end
      RD_X: begin
        state_s = RD_Y;
        if (rem_r >= LEN_W'(2)) begin
          rd_en_s = 1'b1;
          addr_s  = base_r + idx_r + ADDR_W'(1);
        end else begin
          rd_en_s = 1'b0;
        end
      end
      RD_Y: begin
        x_s     = mem_rdata;
        state_s = CAP_Y;
      end
      CAP_Y: begin
        // A lone final element is padded with +0.0 so it adds nothing to the norm.
        y_s     = (rem_r >= LEN_W'(2)) ? mem_rdata : DATA_W'(FP_ZERO);
        last_s  = (rem_r <= LEN_W'(2));
        valid_s = 1'b1;
        state_s = PRESENT;
      end
      PRESENT: begin
        if (pair_ready) begin
          valid_s = 1'b0;
          idx_s   = idx_r + ADDR_W'(2);
          rem_s   = (rem_r >= LEN_W'(2)) ? (rem_r - LEN_W'(2)) : '0;
          if (last_r) begin
            state_s = FIN;
          end else begin
            state_s = RD_X;
            rd_en_s = 1'b1;
            addr_s  = base_r + idx_r + ADDR_W'(2);
          end
        end else begin
          state_s = PRESENT;
        end
      end
      FIN: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State and registered outputs; done trails the FIN cycle by one clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      base_r  <= '0;
      idx_r   <= '0;
      rem_r   <= '0;
      x_r     <= '0;
      y_r     <= '0;
      valid_r <= 1'b0;
      last_r  <= 1'b0;
      rd_en_r <= 1'b0;
      addr_r  <= '0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      base_r  <= base_s;
      idx_r   <= idx_s;
      rem_r   <= rem_s;
      x_r     <= x_s;
      y_r     <= y_s;
      valid_r <= valid_s;
      last_r  <= last_s;
      rd_en_r <= rd_en_s;
      addr_r  <= addr_s;
      busy_r  <= (state_s != IDLE);
      done_r  <= (state_r == FIN);
    end
  end

  assign x          = x_r;
  assign y          = y_r;
  assign pair_valid = valid_r;
  assign pair_last  = last_r;
  assign mem_rd_en  = rd_en_r;
  assign mem_addr   = addr_r;
  assign busy       = busy_r;
  assign done       = done_r;

`ifdef VEC_PAIR_FEEDER_STATS_EN
  logic accept_s, xfer_s, stall_s;
  assign accept_s = (state_r == IDLE) && start;
  assign xfer_s   = (state_r == PRESENT) && pair_ready;
  assign stall_s  = (state_r == PRESENT) && !pair_ready;

  vec_feeder_stats #(.LEN_W(LEN_W)) u_stats (
    .clk         (clk),
    .rst_n       (rst_n),
    .clr         (accept_s),
    .xfer        (xfer_s),
    .stall       (stall_s),
    .stat_pairs  (stat_pairs),
    .stat_stalls (stat_stalls)
  );
`endif

endmodule

// File: tb/tb_vec_pair_feeder.sv
// Self-checking bench for vec_pair_feeder: directed table, random vectors, stall and reset sequences.
module tb_vec_pair_feeder;

  logic        clk = 1'b0;
  logic        rst_n, start, pair_ready;
  logic [7:0]  base_addr;
  logic [8:0]  length;
  logic        mem_rd_en;
  logic [7:0]  mem_addr;
  logic [23:0] mem_rdata;
  logic [23:0] x, y;
  logic        pair_valid, pair_last, busy, done;
`ifdef VEC_PAIR_FEEDER_STATS_EN
  logic [8:0]  stat_pairs;
  logic [15:0] stat_stalls;
`endif

  vec_pair_feeder dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .length(length),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .x(x), .y(y), .pair_valid(pair_valid), .pair_ready(pair_ready), .pair_last(pair_last),
    .busy(busy), .done(done)
`ifdef VEC_PAIR_FEEDER_STATS_EN
    , .stat_pairs(stat_pairs), .stat_stalls(stat_stalls)
`endif
  );

  always #5 clk = ~clk;

  logic [23:0] mem [0:255];
  always @(posedge clk) begin
    if (mem_rd_en) mem_rdata <= mem[mem_addr];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [23:0] x; logic [23:0] y; logic last; int edge_n; } pair_t;
  pair_t got_q[$];
  int    rd_q[$];
  int    fv_q[$];
  int    done_q[$];
  int    busy_n = 0, stall_n = 0, hold_err = 0;
  logic  pv_r = 1'b0, rdy_r = 1'b0, pl_r = 1'b0;
  logic [23:0] px_r = 24'h0, py_r = 24'h0;

  // Observe the interface mid-cycle; transfers and reads take effect at the following edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (mem_rd_en) rd_q.push_back(int'(mem_addr));
      if (pair_valid && !pv_r) fv_q.push_back(cyc);
      if (pair_valid && pair_ready) got_q.push_back('{x, y, pair_last, cyc + 1});
      if (done) done_q.push_back(cyc);
      if (busy) busy_n <= busy_n + 1;
      if (pair_valid && !pair_ready) stall_n <= stall_n + 1;
      if (pair_valid && pv_r && !rdy_r && ({x, y, pair_last} != {px_r, py_r, pl_r}))
        hold_err <= hold_err + 1;
    end
    pv_r  <= pair_valid;
    rdy_r <= pair_ready;
    px_r  <= x;
    py_r  <= y;
    pl_r  <= pair_last;
  end

  int tests = 0, fails = 0;
  int start_edge;

  task automatic chk_i(input string nm, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_v(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Expected k-th pair {x, y, last} straight from the vector definition.
  function automatic logic [48:0] model_pair(input int b, input int len, input int k);
    logic [7:0]  a;
    logic [23:0] ey;
    a  = 8'(b + 2 * k);
    ey = (2 * k + 1 < len) ? mem[8'(a + 8'd1)] : 24'h000000;
    return {mem[a], ey, (k == (len + 1) / 2 - 1)};
  endfunction

  // mode 0: ready always high, 1: random ready, 2: ready low for the first 5 presented cycles.
  task automatic run_vec(input int b, input int len, input int mode, input int exp_np, input bit poke);
    int g0, r0, f0, d0, bz0, st0, h0, vcnt, np;
    for (int i = 0; i < 256; i++) mem[i] = 24'($urandom);
    @(posedge clk); #1;
    g0 = got_q.size(); r0 = rd_q.size(); f0 = fv_q.size(); d0 = done_q.size();
    bz0 = busy_n; st0 = stall_n; h0 = hold_err;
    start = 1'b1; base_addr = 8'(b); length = 9'(len); pair_ready = (mode != 2);
    @(posedge clk); #1;
    start_edge = cyc;
    start = 1'b0; base_addr = 8'($urandom); length = 9'($urandom);
    vcnt = 0;
    for (int c = 0; c < 4000 && done_q.size() == d0; c++) begin
      start = poke && (c == 2);
      if (pair_valid) vcnt++;
      case (mode)
        0:       pair_ready = 1'b1;
        1:       pair_ready = ($urandom_range(0, 9) < 7);
        default: pair_ready = (vcnt > 5);
      endcase
      @(posedge clk); #1;
    end
    start = 1'b0; pair_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    np = (len + 1) / 2;
    chk_i("done_count", done_q.size() - d0, 1);
    chk_i("pair_count", got_q.size() - g0, exp_np);
    for (int k = 0; k < np && g0 + k < got_q.size(); k++)
      chk_v("pair_data", 64'({got_q[g0+k].x, got_q[g0+k].y, got_q[g0+k].last}),
            64'(model_pair(b, len, k)));
    chk_i("read_count", rd_q.size() - r0, len);
    for (int i = 0; i < len && r0 + i < rd_q.size(); i++)
      chk_i("read_addr", rd_q[r0+i], (b + i) % 256);
    if (len == 0) begin
      if (done_q.size() > d0) chk_i("len0_done_lat", done_q[d0] - start_edge, 1);
      chk_i("len0_busy_cycles", busy_n - bz0, 1);
      chk_i("len0_no_valid", fv_q.size() - f0, 0);
    end else if (done_q.size() > d0 && got_q.size() > g0) begin
      chk_i("done_after_last", done_q[d0] - got_q[got_q.size()-1].edge_n, 1);
    end
    if (mode == 0 && len > 0) begin
      if (fv_q.size() > f0) chk_i("first_valid_lat", fv_q[f0] - start_edge, 3);
      for (int k = 1; k < np && g0 + k < got_q.size(); k++)
        chk_i("pair_interval", got_q[g0+k].edge_n - got_q[g0+k-1].edge_n, 4);
      chk_i("no_stalls", stall_n - st0, 0);
    end
    if (mode == 2) chk_i("stall_cycles", stall_n - st0, 5);
    chk_i("hold_stable", hold_err - h0, 0);
`ifdef VEC_PAIR_FEEDER_STATS_EN
    chk_i("stat_pairs", int'(stat_pairs), np);
    chk_i("stat_stalls", int'(stat_stalls), (mode == 2) ? 5 : stall_n - st0);
`endif
    if (poke) chk_i("ignored_start_idle", int'(busy), 0);
  endtask

  typedef struct { int b; int len; int mode; int np; bit poke; } vec_t;
  vec_t tbl [10];

  initial begin
    int d0;
    bit seen;
    tbl[0] = '{32'h10, 4,   0, 2,   1'b0};
    tbl[1] = '{32'h20, 3,   0, 2,   1'b0};
    tbl[2] = '{32'h00, 1,   0, 1,   1'b0};
    tbl[3] = '{32'h80, 0,   0, 0,   1'b0};
    tbl[4] = '{32'hFF, 2,   0, 1,   1'b1};
    tbl[5] = '{32'h44, 2,   2, 1,   1'b0};
    tbl[6] = '{32'hFE, 5,   1, 3,   1'b0};
    tbl[7] = '{32'hF0, 40,  1, 20,  1'b0};
    tbl[8] = '{32'h05, 300, 1, 150, 1'b0};
    tbl[9] = '{32'h7F, 511, 0, 256, 1'b0};

    rst_n = 1'b0; start = 1'b0; base_addr = 8'h00; length = 9'd0; pair_ready = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = 24'h000000;
    repeat (3) @(posedge clk);
    #1;
    chk_v("reset_outputs", 64'({x, y, pair_valid, pair_last, mem_rd_en, mem_addr, busy, done}), 64'd0);
`ifdef VEC_PAIR_FEEDER_STATS_EN
    chk_v("reset_stats", 64'({stat_pairs, stat_stalls}), 64'd0);
`endif
    rst_n = 1'b1;

    for (int t = 0; t < 10; t++)
      run_vec(tbl[t].b, tbl[t].len, tbl[t].mode, tbl[t].np, tbl[t].poke);

    for (int r = 0; r < 12; r++) begin
      int len;
      len = int'($urandom_range(0, 12));
      run_vec(int'($urandom_range(0, 255)), len, int'($urandom_range(0, 1)), (len + 1) / 2, 1'b0);
    end

    // Asynchronous reset while a pair is being presented.
    @(posedge clk); #1;
    d0 = done_q.size();
    start = 1'b1; base_addr = 8'h40; length = 9'd4; pair_ready = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(posedge clk); #1;
      seen = pair_valid;
    end
    chk_i("rst_reached_present", int'(seen), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_v("rst_async_outputs", 64'({x, y, pair_valid, pair_last, mem_rd_en, mem_addr, busy, done}), 64'd0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk_i("rst_no_done", done_q.size() - d0, 0);
    run_vec(32'h30, 6, 0, 3, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
